// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and helpers for the extended UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [2:0] PAR_NONE  = 3'b000;
    localparam logic [2:0] PAR_EVEN  = 3'b001;
    localparam logic [2:0] PAR_ODD   = 3'b010;
    localparam logic [2:0] PAR_MARK  = 3'b011;
    localparam logic [2:0] PAR_SPACE = 3'b100;

    localparam logic [1:0] STOP_0P5 = 2'b00;
    localparam logic [1:0] STOP_1   = 2'b01;
    localparam logic [1:0] STOP_1P5 = 2'b10;
    localparam logic [1:0] STOP_2   = 2'b11;

    // data_bits 00..11 maps to 5..8 payload bits; stored as index of the last bit
    localparam logic [2:0] DATA_LAST_BASE = 3'd4;

    function automatic logic [2:0] data_last(input logic [1:0] db);
        return DATA_LAST_BASE + {1'b0, db};
    endfunction

    function automatic logic parity_enabled(input logic [2:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
               (mode == PAR_MARK) || (mode == PAR_SPACE);
    endfunction

    function automatic logic parity_bit(input logic [7:0] word, input logic [2:0] last,
                                        input logic [2:0] mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i <= int'(last)) x = x ^ word[i];
        end
        case (mode)
            PAR_EVEN: return x;
            PAR_ODD:  return ~x;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with occupancy level, pushes dropped when full
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    // a full buffer refuses the write even when a pop frees a slot on the same edge
    assign do_push = push && !full;
    assign do_pop  = pop && (level != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ext.sv
// rtl/uart_tx_ext.sv - buffered UART transmitter with per-frame latched format
module uart_tx_ext import uart_pkg::*; #(
    parameter int FIFO_DEPTH = 8,
    parameter int CTR_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CTR_W-1:0]              bit_duration,
    input  logic [1:0]                    data_bits,
    input  logic [2:0]                    parity_mode,
    input  logic [1:0]                    stopbits,
    input  logic                          tx_en,
    input  logic                          s_valid,
    input  logic [7:0]                    s_data,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          tx_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    state_t           state_q, state_d;
    logic [CTR_W-1:0] cnt_q, cnt_d, bd_q, bd_d;
    logic [2:0]       idx_q, idx_d, last_q, last_d, par_q, par_d;
    logic [1:0]       sb_q, sb_d;
    logic [7:0]       word_q, word_d, head;
    logic             tx_q, tx_d;
    logic             launch, enter_stop, can_start, fifo_full;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid),
        .wdata (s_data),
        .pop   (launch),
        .rdata (head),
        .level (fifo_level),
        .full  (fifo_full)
    );

    assign s_ready = !fifo_full;
    assign tx      = tx_q;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        tx_d       = tx_q;
        word_d     = word_q;
        bd_d       = bd_q;
        last_d     = last_q;
        par_d      = par_q;
        sb_d       = sb_q;
        launch     = 1'b0;
        enter_stop = 1'b0;
        tx_done    = 1'b0;
        can_start  = tx_en && (fifo_level != '0);

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                launch = can_start;
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = bd_q;
                    idx_d   = 3'd0;
                    tx_d    = word_q[0];
                end else begin
                    cnt_d = cnt_q - CTR_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = bd_q;
                    if (idx_q == last_q) begin
                        if (parity_enabled(par_q)) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit(word_q, last_q, par_q);
                        end else begin
                            enter_stop = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = word_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - CTR_W'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == '0) enter_stop = 1'b1;
                else             cnt_d = cnt_q - CTR_W'(1);
            end
            ST_STOP: begin
                // idx counts remaining stop phases; the second phase is half or full
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CTR_W'(1);
                end else if (idx_q != 3'd0) begin
                    idx_d = 3'd0;
                    cnt_d = (sb_q == STOP_1P5) ? (bd_q >> 1) : bd_q;
                end else begin
                    tx_done = 1'b1;
                    state_d = ST_IDLE;
                    launch  = can_start;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_stop) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
            cnt_d   = (sb_q == STOP_0P5) ? (bd_q >> 1) : bd_q;
            idx_d   = {2'b00, sb_q[1]};
        end

        if (launch) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            cnt_d   = bit_duration;
            word_d  = head;
            bd_d    = bit_duration;
            last_d  = data_last(data_bits);
            par_d   = parity_mode;
            sb_d    = stopbits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            word_q  <= '0;
            bd_q    <= '0;
            last_q  <= '0;
            par_q   <= PAR_NONE;
            sb_q    <= STOP_1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            word_q  <= word_d;
            bd_q    <= bd_d;
            last_q  <= last_d;
            par_q   <= par_d;
            sb_q    <= sb_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ext.sv
// tb/tb_uart_tx_ext.sv - self-checking bench for uart_tx_ext against a per-clock line model
module tb_uart_tx_ext;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bit_duration;
    logic [1:0]  data_bits;
    logic [2:0]  parity_mode;
    logic [1:0]  stopbits;
    logic        tx_en;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        tx;
    logic        tx_done;
    logic        busy;
    logic [2:0]  fifo_level;

    int tests = 0;
    int fails = 0;

    bit exp_q[$];
    int len_q[$];
    int mon_rem   = 0;
    int frame_err = 0;
    int stray     = 0;
    int idle_err  = 0;
    int wr_to     = 0;

    typedef struct {
        logic [1:0] db;
        logic [2:0] pm;
        logic [1:0] sb;
        int         bd;
        logic [7:0] w;
        int         exp_len;
    } vec_t;

    vec_t vecs[9];

    uart_tx_ext #(.FIFO_DEPTH(DEPTH), .CTR_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_duration (bit_duration),
        .data_bits    (data_bits),
        .parity_mode  (parity_mode),
        .stopbits     (stopbits),
        .tx_en        (tx_en),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .tx           (tx),
        .tx_done      (tx_done),
        .busy         (busy),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Expected line level for every clock of one frame, from the framing rules.
    task automatic model_frame(input logic [7:0] w, input logic [1:0] db, input logic [2:0] pm,
                               input logic [1:0] sb, input int bd);
        int p, half, nb, ones, total, stop_clks;
        bit pb;
        p = bd + 1;
        half = bd / 2 + 1;
        nb = 5 + int'(db);
        ones = 0;
        total = 0;
        for (int c = 0; c < p; c++) exp_q.push_back(1'b0);
        total += p;
        for (int i = 0; i < nb; i++) begin
            ones += int'(w[i]);
            for (int c = 0; c < p; c++) exp_q.push_back(w[i]);
            total += p;
        end
        if (pm >= 3'd1 && pm <= 3'd4) begin
            case (pm)
                3'd1:    pb = (ones % 2) == 1;
                3'd2:    pb = (ones % 2) == 0;
                3'd3:    pb = 1'b1;
                default: pb = 1'b0;
            endcase
            for (int c = 0; c < p; c++) exp_q.push_back(pb);
            total += p;
        end
        case (sb)
            2'd0:    stop_clks = half;
            2'd1:    stop_clks = p;
            2'd2:    stop_clks = p + half;
            default: stop_clks = 2 * p;
        endcase
        for (int c = 0; c < stop_clks; c++) exp_q.push_back(1'b1);
        total += stop_clks;
        len_q.push_back(total);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            len_q.delete();
            mon_rem = 0;
            frame_err = 0;
        end else begin
            if (mon_rem == 0 && tx === 1'b0) begin
                if (len_q.size() == 0) begin
                    stray++;
                end else begin
                    mon_rem = len_q.pop_front();
                    frame_err = 0;
                end
            end
            if (mon_rem > 0) begin
                if (tx !== exp_q.pop_front()) frame_err++;
                if (tx_done !== (mon_rem == 1)) frame_err++;
                if (busy !== 1'b1) frame_err++;
                mon_rem--;
                if (mon_rem == 0) check("frame_waveform_errors", frame_err, 0);
            end else if (tx === 1'b1) begin
                if (tx_done !== 1'b0 || busy !== 1'b0) idle_err++;
            end
        end
    end

    task automatic set_cfg(input logic [1:0] db, input logic [2:0] pm, input logic [1:0] sb,
                           input int bd);
        data_bits = db;
        parity_mode = pm;
        stopbits = sb;
        bit_duration = 16'(bd);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic write_word(input logic [7:0] w, output int k);
        k = 0;
        s_valid = 1'b1;
        s_data = w;
        while (!s_ready && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 500) wr_to++;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy || fifo_level != 3'd0 || mon_rem != 0 || len_q.size() != 0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(k < 5000), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic count_lows(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int k, lat, len, lows, g, n;
        logic [7:0] w;
        logic [1:0] db, sb;
        logic [2:0] pm;
        int bd;

        vecs[0] = '{2'd3, 3'd0, 2'd1, 3, 8'hA5, 40};
        vecs[1] = '{2'd2, 3'd1, 2'd3, 1, 8'h55, 22};
        vecs[2] = '{2'd3, 3'd0, 2'd0, 7, 8'h3C, 76};
        vecs[3] = '{2'd3, 3'd0, 2'd2, 7, 8'hC3, 84};
        vecs[4] = '{2'd0, 3'd2, 2'd1, 0, 8'hF6, 8};
        vecs[5] = '{2'd0, 3'd0, 2'd0, 0, 8'h0B, 7};
        vecs[6] = '{2'd1, 3'd3, 2'd3, 2, 8'h2A, 30};
        vecs[7] = '{2'd2, 3'd7, 2'd2, 5, 8'h81, 57};
        vecs[8] = '{2'd3, 3'd4, 2'd0, 1, 8'hFF, 21};

        rst_n = 1'b0;
        tx_en = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        set_cfg(2'd3, 3'd0, 2'd1, 3);
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_tx_done", int'(tx_done), 0);
        check("reset_level", int'(fifo_level), 0);
        check("reset_s_ready", int'(s_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            set_cfg(vecs[i].db, vecs[i].pm, vecs[i].sb, vecs[i].bd);
            model_frame(vecs[i].w, vecs[i].db, vecs[i].pm, vecs[i].sb, vecs[i].bd);
            write_word(vecs[i].w, k);
            lat = 0;
            @(negedge clk);
            while (tx !== 1'b0 && lat < 50) begin
                lat++;
                @(negedge clk);
            end
            check("start_latency", lat, 1);
            len = 1;
            while (tx_done !== 1'b1 && len < 2000) begin
                @(negedge clk);
                len++;
            end
            check("frame_length", len, vecs[i].exp_len);
            wait_idle("idle_after_vector");
        end

        set_cfg(2'd3, 3'd0, 2'd1, 0);
        for (int i = 0; i < 6; i++) model_frame(8'(8'h30 + i), 2'd3, 3'd0, 2'd1, 0);
        fork
            begin : b2b_writer
                int kk;
                for (int i = 0; i < 6; i++) begin
                    write_word(8'(8'h30 + i), kk);
                    if (i == 4) begin
                        check("full_s_ready", int'(s_ready), 0);
                        check("full_level", int'(fifo_level), 4);
                    end
                    if (i == 5) check("sixth_held_cycles", kk, 7);
                end
            end
            begin : b2b_measure
                int c, d, gg;
                c = 0;
                d = 0;
                gg = 0;
                while (tx !== 1'b0 && gg < 100) begin
                    @(negedge clk);
                    gg++;
                end
                c = 1;
                while (gg < 1000) begin
                    if (tx_done === 1'b1) d++;
                    if (d == 6) break;
                    @(negedge clk);
                    c++;
                    gg++;
                end
                check("b2b_total_clocks", c, 60);
                check("b2b_done_pulses", d, 6);
            end
        join
        wait_idle("idle_after_b2b");

        set_cfg(2'd3, 3'd0, 2'd1, 3);
        tx_en = 1'b0;
        write_word(8'h12, k);
        write_word(8'h34, k);
        count_lows(20, lows);
        check("disabled_no_start", lows, 0);
        check("disabled_level", int'(fifo_level), 2);
        check("disabled_busy", int'(busy), 0);
        model_frame(8'h12, 2'd3, 3'd0, 2'd1, 3);
        model_frame(8'h34, 2'd3, 3'd0, 2'd1, 3);
        tx_en = 1'b1;
        wait_idle("idle_after_enable");

        model_frame(8'h56, 2'd3, 3'd0, 2'd1, 3);
        write_word(8'h56, k);
        write_word(8'h78, k);
        repeat (6) @(posedge clk);
        #1;
        tx_en = 1'b0;
        g = 0;
        while ((busy || mon_rem != 0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("drop_en_frame_completes", int'(g < 500 && len_q.size() == 0), 1);
        count_lows(10, lows);
        check("drop_en_no_second_start", lows, 0);
        check("drop_en_level", int'(fifo_level), 1);
        check("drop_en_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        model_frame(8'h78, 2'd3, 3'd0, 2'd1, 3);
        tx_en = 1'b1;
        wait_idle("idle_after_reenable");

        for (int i = 0; i < 4; i++) model_frame(8'(8'hA0 + i), 2'd3, 3'd0, 2'd1, 3);
        for (int i = 0; i < 4; i++) write_word(8'(8'hA0 + i), k);
        check("pre_reset_level", int'(fifo_level), 3);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_tx", int'(tx), 1);
        check("abort_level", int'(fifo_level), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_tx_done", int'(tx_done), 0);
        check("abort_s_ready", int'(s_ready), 1);
        n = 0;
        lows = 0;
        repeat (2) begin
            @(negedge clk);
            if (tx_done !== 1'b0) n++;
            if (tx !== 1'b1) lows++;
        end
        check("abort_no_tx_done", n, 0);
        check("abort_tx_held_high", lows, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_lows(20, lows);
        check("post_reset_silent", lows, 0);
        check("post_reset_level", int'(fifo_level), 0);
        @(posedge clk);
        #1;

        for (int it = 0; it < 12; it++) begin
            db = 2'($urandom_range(0, 3));
            pm = 3'($urandom_range(0, 7));
            sb = 2'($urandom_range(0, 3));
            bd = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 3));
            set_cfg(db, pm, sb, bd);
            for (int j = 0; j < n; j++) begin
                w = 8'($urandom);
                model_frame(w, db, pm, sb, bd);
                write_word(w, k);
            end
            g = 0;
            while (fifo_level != 3'd0 && g < 2000) begin
                @(posedge clk);
                #1;
                g++;
            end
            set_cfg(2'($urandom), 3'($urandom), 2'($urandom), int'($urandom_range(0, 65535)));
            wait_idle("idle_after_random");
        end

        check("stray_frame_starts", stray, 0);
        check("idle_busy_or_done_errors", idle_err, 0);
        check("write_timeouts", wr_to, 0);
        check("unconsumed_model_clocks", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_ext.md
UART_TX_EXT -- requirements
Module: uart_tx_ext

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, transmit-buffer depth in words; power of two, 2..256.
REQ-002 SHALL have parameter CTR_W, default 16, width of the bit-duration counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port bit_duration  input  CTR_W  clocks per bit minus one.
REQ-006 SHALL have port data_bits  input  2  payload length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-007 SHALL have port parity_mode  input  3  000 none, 001 even, 010 odd, 011 mark, 100 space; 101-111 treated as none.
REQ-008 SHALL have port stopbits  input  2  00=0.5, 01=1, 10=1.5, 11=2 stop bits.
REQ-009 SHALL have port tx_en  input  1  when low, no new frame starts; a frame in progress completes.
REQ-010 SHALL have port s_valid  input  1  write request.
REQ-011 SHALL have port s_data  input  8  write word; bits above the payload length are ignored.
REQ-012 SHALL have port s_ready  output  1  buffer can accept a word.
REQ-013 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-014 SHALL have port tx_done  output  1  one-cycle pulse at the end of each frame.
REQ-015 SHALL have port busy  output  1  high from frame start to end of last stop bit.
REQ-016 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words buffered.

Function
REQ-017 SHALL accept a word on any rising edge with s_valid && s_ready; s_ready = (fifo_level != FIFO_DEPTH), combinational from level only.
REQ-018 SHALL ignore a write when full, even if a pop occurs in the same cycle; the word is not stored.
REQ-019 SHALL update fifo_level by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-020 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 SHALL, in IDLE with tx_en=1 and level>0, pop one word on the edge, latch word, bit_duration, data_bits, parity_mode and stopbits, drive tx<=0 and enter START; config changes mid-frame have no effect.
REQ-022 SHALL, for a word accepted into an empty buffer while IDLE at edge N, drive tx low from edge N+1.
REQ-023 SHALL hold every full bit for bit_duration+1 clocks; bit_duration=0 gives one-clock bits.
REQ-024 SHALL send the payload LSB first in DATA, for the latched payload length.
REQ-025 SHALL enter PARITY only when parity is enabled; even=XOR of payload bits, odd=inverse, mark=1, space=0.
REQ-026 SHALL drive tx=1 in STOP, with stop duration: 0.5 = (bit_duration>>1)+1 clocks; 1 = one bit period; 1.5 = one bit period + half period; 2 = two bit periods.
REQ-027 SHALL, at the last clock of STOP, pulse tx_done for one cycle and go to IDLE or START.
REQ-028 SHALL go directly to START on that same edge if tx_en=1 and level>0, popping the next word, with no idle gap between frames.
REQ-029 SHALL drive busy=1 in START, DATA, PARITY and STOP, and busy=0 in IDLE.
REQ-030 SHALL have no effect from tx_en falling mid-frame on the frame in progress; the FSM returns to IDLE and holds tx=1.

Reset
REQ-031 SHALL, with rst_n low, immediately set tx=1, tx_done=0, busy=0, fifo_level=0, state IDLE, and all counters and pointers to 0.
REQ-032 SHALL drop buffered words and abort a frame in progress when reset is asserted; tx returns high without glitch to 0.
REQ-033 SHALL drive s_ready=1 during and after reset.

Structure
REQ-034 SHALL place state enum, parity_mode and stopbits encodings, and data_bits decode constants in shared package uart_pkg.
REQ-035 SHALL implement the buffer as sub-module uart_fifo, a synchronous FIFO with level output, parameterised on width and depth.
REQ-036 SHALL keep one bit-duration counter and one bit index counter in the FSM, with no arithmetic wider than CTR_W+1.

Verification
REQ-037 SHALL cover: bit_duration=3, 8N1, write 0xA5 -> tx low 4 clk, then 1,0,1,0,0,1,0,1 each 4 clk, high 4 clk, tx_done pulse once.
REQ-038 SHALL cover: 7E2 (data_bits=10, parity=001), bit_duration=1, 0x55 -> 7 data bits, parity bit=0, stop high 4 clk.
REQ-039 SHALL cover: FIFO_DEPTH=4, 6 writes back-to-back while idle -> s_ready low after 5th accepted (one popped), 6th held; frames contiguous, tx_done ×6.
REQ-040 SHALL cover: stopbits=00 then 10, bit_duration=7 -> stop lasts 4 then 12 clocks.
REQ-041 SHALL cover: tx_en=0 with 2 words queued -> no start; tx_en=1 -> frames sent; tx_en dropped mid-frame -> frame completes, second not started.
REQ-042 SHALL cover: rst_n asserted mid-DATA with 3 words queued -> tx=1, level=0, busy=0 immediately, no tx_done.
